branch_target_predictor: RTL and testbench
==========================================

Name: branch_target_predictor

Overview:
- Parametrised next-generation front-end predictor for the pentary 5-stage pipeline: 2-bit saturating-counter BHT plus tagged BTB, so the IF stage gets both direction and target.
- Sits beside IF: PC in, registered prediction out one cycle later.
- EX-stage branch resolution feeds updates back; the block raises a one-cycle redirect on mispredict.
- Self-initialising table sweep after reset.

Parameters:
- PC_W, 48, PC and target width.
- ENTRIES, 256, BHT/BTB entries; power of two, >= 4.
- TAG_W, 10, BTB tag width.
- STRIDE_LOG2, 2, log2 of instruction stride in bytes; fall-through = pc + (1<<STRIDE_LOG2).
- INIT_CTR, 2'b01, counter value written by the init sweep (weakly not taken).
- HIST_W, 8, global history length; used only with GSHARE_EN; must be <= log2(ENTRIES).

Ports:
- clk, in, 1, single clock, rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- ready, out, 1, high when tables are initialised (RUN state).
- pred_req, in, 1, prediction request for pred_pc.
- pred_pc, in, PC_W, fetch PC.
- pred_resp_valid, out, 1, response valid; asserts the cycle after an accepted pred_req.
- pred_taken, out, 1, predicted direction.
- pred_hit, out, 1, BTB tag hit.
- pred_target, out, PC_W, predicted next PC.
- upd_valid, in, 1, resolved branch from EX.
- upd_pc, in, PC_W, PC of the resolved branch.
- upd_taken, in, 1, actual direction.
- upd_target, in, PC_W, actual taken target.
- upd_pred_taken, in, 1, direction that was predicted for this branch.
- upd_pred_target, in, PC_W, next PC that was predicted for this branch.
- redirect_valid, out, 1, mispredict redirect pulse.
- redirect_pc, out, PC_W, corrected fetch PC.

Behaviour:
- Address fields:
  - idx = pc[STRIDE_LOG2 +: log2(ENTRIES)].
  - tag = the next TAG_W bits above idx.
- Entry contents:
  - BHT entry: 2-bit counter.
  - BTB entry: valid bit, tag, target.
- Async reset (reset_n low): state=INIT, sweep index=0, every output 0; table contents undefined until the sweep completes.
- INIT state:
  - One entry per cycle: BTB valid cleared, counter set to INIT_CTR.
  - Takes ENTRIES cycles after reset release; then ready=1, state=RUN.
  - pred_req ignored (pred_resp_valid stays 0); upd_valid dropped; redirect_valid stays 0.
- Reset asserted mid-sweep or mid-RUN: returns to INIT at index 0 and re-sweeps fully.
- RUN, prediction (latency 1):
  - pred_req at cycle N gives pred_resp_valid=1 at N+1; response outputs hold until the next accepted request.
  - pred_resp_valid is 0 in cycles without a request.
  - hit = valid && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = pred_taken ? btb_target : pred_pc + stride, computed modulo 2^PC_W.
- RUN, update (write at the clock edge):
  - Counter: +1 on taken, saturating at 11; -1 on not taken, saturating at 00.
  - Taken: BTB entry written valid=1 with the new tag and upd_target; this replaces an aliasing entry.
  - Not taken: BTB entry unchanged.
- Same-index predict and update in the same cycle: prediction returns pre-update contents (read-before-write); update still commits.
- Mispredict condition: upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
  - Next cycle: redirect_valid=1 for exactly one cycle.
  - redirect_pc = upd_taken ? upd_target : upd_pc + stride.
  - Back-to-back mispredicts give back-to-back pulses, each carrying its own PC.
- redirect_pc and pred_target hold their last values while not valid.

Optional Feature:
- BTP_GSHARE_EN defined:
  - HIST_W-bit global history register, cleared by reset and held at 0 during INIT.
  - BHT index = idx XOR zero-extended history; BTB still PC-indexed.
  - History shifts in upd_taken, LSB first, on every RUN update.
  - Prediction uses the history value before that cycle's shift.
- Undefined: bimodal indexing, no history register.

Test Plan:
- Reset and init: release reset_n with ENTRIES=256 -> ready=0 for 256 cycles, then 1. pred_req pc=0x100 -> pred_resp_valid next cycle, taken=0, hit=0, target=0x104.
- Train: one update pc=0x100, taken=1, target=0x800 -> counter 01->10; predict 0x100 -> taken=1, hit=1, target=0x800.
- Saturate and decay: 3 more taken updates, then 2 not-taken at 0x100 -> counter 11->01; predict -> taken=0, hit=1, target=0x104.
- Alias: after training 0x100, predict 0x500 (same idx, different tag) -> hit=0, taken=0, target=0x504. Taken update at 0x500 -> then predicting 0x100 gives hit=0.
- Mispredict: upd pc=0x100, pred_taken=0, taken=1, target=0x800 -> redirect_valid=1 one cycle, redirect_pc=0x800. Matching prediction -> no redirect.
- Corner cases:
  - Predict and update 0x100 in the same cycle -> response shows the old counter.
  - reset_n low at sweep cycle 100 -> ready stays 0 for a full 256 cycles after release.

Source files
------------

// File: rtl/branch_target_predictor_if.sv
// -----------------------------------------------------------------------------
// branch_target_predictor_if
// Bus bundle between the fetch/execute side and branch_target_predictor.
//   master : drives prediction requests and EX-stage updates, receives the
//            registered prediction and the mispredict redirect.
//   slave  : the predictor side of the same signals.
// Signals:
//   pred_req/pred_pc                      fetch-side prediction request
//   pred_resp_valid/taken/hit/target      registered prediction (1 cycle later)
//   upd_valid/pc/taken/target             resolved branch from EX
//   upd_pred_taken/upd_pred_target        what was predicted for that branch
//   redirect_valid/redirect_pc            one-cycle mispredict redirect
// -----------------------------------------------------------------------------
interface branch_target_predictor_if #(
  parameter int unsigned PC_W = 48
);
  logic            pred_req;
  logic [PC_W-1:0] pred_pc;
  logic            pred_resp_valid;
  logic            pred_taken;
  logic            pred_hit;
  logic [PC_W-1:0] pred_target;

  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic            upd_pred_taken;
  logic [PC_W-1:0] upd_pred_target;

  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;

  modport master (
    output pred_req, pred_pc,
    output upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
    input  pred_resp_valid, pred_taken, pred_hit, pred_target,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  pred_req, pred_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
    output pred_resp_valid, pred_taken, pred_hit, pred_target,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/branch_target_predictor.sv
// -----------------------------------------------------------------------------
// branch_target_predictor
// Front-end predictor beside IF: 2-bit saturating-counter BHT plus a tagged
// BTB. A request is answered one cycle later with direction, BTB hit and next
// PC. EX-stage resolutions train the tables and raise a one-cycle redirect on
// mispredict. After reset the tables are swept one entry per cycle (INIT),
// then ready rises (RUN).
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   ready    high once the init sweep is complete
//   bus      branch_target_predictor_if.slave (prediction/update/redirect)
// Optional build macro: BTP_GSHARE_EN -- XOR an HIST_W-bit global history
//   into the BHT index (BTB stays PC-indexed). Undefined: bimodal indexing.
// -----------------------------------------------------------------------------
module branch_target_predictor #(
  parameter int unsigned PC_W        = 48,
  parameter int unsigned ENTRIES     = 256,
  parameter int unsigned TAG_W       = 10,
  parameter int unsigned STRIDE_LOG2 = 2,
  parameter logic [1:0]  INIT_CTR    = 2'b01,
  parameter int unsigned HIST_W      = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  output logic                      ready,
  branch_target_predictor_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [PC_W-1:0] STRIDE = PC_W'(1) << STRIDE_LOG2;

  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t state, state_nxt;

  logic [IDX_W-1:0] sweep_idx;
  logic             run;

  // Tables carry no reset; the INIT sweep establishes their contents.
  logic [1:0]       bht        [ENTRIES];
  logic             btb_valid  [ENTRIES];
  logic [TAG_W-1:0] btb_tag    [ENTRIES];
  logic [PC_W-1:0]  btb_target [ENTRIES];

  logic [IDX_W-1:0] pred_idx, upd_idx, pred_bht_idx, upd_bht_idx;
  logic [TAG_W-1:0] pred_tag, upd_tag;
  logic             hit, taken, mispredict;
  logic [1:0]       ctr_next;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pred_pc, bus.upd_pc};

  assign pred_idx = bus.pred_pc[STRIDE_LOG2 +: IDX_W];
  assign pred_tag = bus.pred_pc[STRIDE_LOG2 + IDX_W +: TAG_W];
  assign upd_idx  = bus.upd_pc[STRIDE_LOG2 +: IDX_W];
  assign upd_tag  = bus.upd_pc[STRIDE_LOG2 + IDX_W +: TAG_W];

`ifdef BTP_GSHARE_EN
  logic [HIST_W-1:0] ghist;

  // History is pinned at zero through INIT and advances on every RUN update;
  // both lookups in a cycle use the value from before that cycle's shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           ghist <= '0;
    else if (!run)          ghist <= '0;
    else if (bus.upd_valid) ghist <= (ghist << 1) | HIST_W'(bus.upd_taken);
  end

  assign pred_bht_idx = pred_idx ^ IDX_W'(ghist);
  assign upd_bht_idx  = upd_idx  ^ IDX_W'(ghist);
`else
  assign pred_bht_idx = pred_idx;
  assign upd_bht_idx  = upd_idx;
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_INIT;
      sweep_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT) sweep_idx <= sweep_idx + 1'b1;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (sweep_idx == IDX_W'(ENTRIES - 1)) state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_INIT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready = 1'b0;
    run   = 1'b0;
    if (state == S_RUN) begin
      ready = 1'b1;
      run   = 1'b1;
    end
  end

  // Lookup and training arithmetic
  always_comb begin
    hit      = btb_valid[pred_idx] && (btb_tag[pred_idx] == pred_tag);
    taken    = hit && bht[pred_bht_idx][1];
    ctr_next = bht[upd_bht_idx];
    if (bus.upd_taken) begin
      if (ctr_next != 2'b11) ctr_next = ctr_next + 2'b01;
    end else begin
      if (ctr_next != 2'b00) ctr_next = ctr_next - 2'b01;
    end
    mispredict = bus.upd_valid &&
                 ((bus.upd_taken != bus.upd_pred_taken) ||
                  (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));
  end

  // Table writes; the registered read below samples pre-edge contents, which
  // gives read-before-write for a same-index predict/update pair.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      bht[sweep_idx]       <= INIT_CTR;
      btb_valid[sweep_idx] <= 1'b0;
    end else if (bus.upd_valid) begin
      bht[upd_bht_idx] <= ctr_next;
      if (bus.upd_taken) begin
        btb_valid[upd_idx]  <= 1'b1;
        btb_tag[upd_idx]    <= upd_tag;
        btb_target[upd_idx] <= bus.upd_target;
      end
    end
  end

  // Registered responses; payloads hold until the next valid event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.pred_resp_valid <= 1'b0;
      bus.pred_taken      <= 1'b0;
      bus.pred_hit        <= 1'b0;
      bus.pred_target     <= '0;
      bus.redirect_valid  <= 1'b0;
      bus.redirect_pc     <= '0;
    end else begin
      bus.pred_resp_valid <= run && bus.pred_req;
      if (run && bus.pred_req) begin
        bus.pred_taken  <= taken;
        bus.pred_hit    <= hit;
        bus.pred_target <= taken ? btb_target[pred_idx] : bus.pred_pc + STRIDE;
      end
      bus.redirect_valid <= run && mispredict;
      if (run && mispredict)
        bus.redirect_pc <= bus.upd_taken ? bus.upd_target : bus.upd_pc + STRIDE;
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
module tb_branch_target_predictor;

  localparam int unsigned PC_W = 48;

  logic clk;
  logic reset_n;
  logic ready;

  branch_target_predictor_if #(.PC_W(PC_W)) bus ();

  branch_target_predictor #(
    .PC_W(PC_W), .ENTRIES(256), .TAG_W(10), .STRIDE_LOG2(2),
    .INIT_CTR(2'b01), .HIST_W(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ready(ready),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic            taken;
    logic            hit;
    logic [PC_W-1:0] target;
  } pexp_t;

  pexp_t           pq[$];
  logic [PC_W-1:0] rq[$];

  int compared   = 0;
  int mismatched = 0;

  logic            have_plast = 1'b0;
  logic [PC_W-1:0] plast;
  logic            have_rlast = 1'b0;
  logic [PC_W-1:0] rlast;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a response.
  always @(negedge clk) begin
    if (bus.pred_resp_valid === 1'b1) begin
      if (pq.size() == 0) begin
        check("pred_unexpected_valid", 64'(bus.pred_resp_valid), 64'd0);
      end else begin
        pexp_t e;
        e = pq.pop_front();
        check("pred_taken",  64'(bus.pred_taken),  64'(e.taken));
        check("pred_hit",    64'(bus.pred_hit),    64'(e.hit));
        check("pred_target", 64'(bus.pred_target), 64'(e.target));
        plast      = e.target;
        have_plast = 1'b1;
      end
    end else if (have_plast) begin
      check("pred_target_hold", 64'(bus.pred_target), 64'(plast));
    end

    if (bus.redirect_valid === 1'b1) begin
      if (rq.size() == 0) begin
        check("redirect_unexpected_valid", 64'(bus.redirect_valid), 64'd0);
      end else begin
        rlast      = rq.pop_front();
        have_rlast = 1'b1;
        check("redirect_pc", 64'(bus.redirect_pc), 64'(rlast));
      end
    end else if (have_rlast) begin
      check("redirect_pc_hold", 64'(bus.redirect_pc), 64'(rlast));
    end
  end

  task automatic set_pred(input logic [PC_W-1:0] pc, input logic et, input logic eh,
                          input logic [PC_W-1:0] etgt);
    pexp_t e;
    bus.pred_req = 1'b1;
    bus.pred_pc  = pc;
    e.taken  = et;
    e.hit    = eh;
    e.target = etgt;
    pq.push_back(e);
  endtask

  task automatic set_upd(input logic [PC_W-1:0] pc, input logic tk, input logic [PC_W-1:0] tgt,
                         input logic ptk, input logic [PC_W-1:0] ptgt,
                         input logic exp_redir, input logic [PC_W-1:0] exp_rpc);
    bus.upd_valid       = 1'b1;
    bus.upd_pc          = pc;
    bus.upd_taken       = tk;
    bus.upd_target      = tgt;
    bus.upd_pred_taken  = ptk;
    bus.upd_pred_target = ptgt;
    if (exp_redir) rq.push_back(exp_rpc);
  endtask

  task automatic tick();
    @(posedge clk); #1;
    bus.pred_req  = 1'b0;
    bus.upd_valid = 1'b0;
  endtask

  // Counts edges from reset release until ready; requests and mispredicting
  // updates are held active throughout and must be ignored.
  task automatic wait_ready(input string name);
    int n = 0;
    bus.pred_req = 1'b1; bus.pred_pc = 48'h100;
    bus.upd_valid = 1'b1; bus.upd_pc = 48'h100; bus.upd_taken = 1'b1;
    bus.upd_target = 48'h800; bus.upd_pred_taken = 1'b0; bus.upd_pred_target = 48'h104;
    while (n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (ready) break;
    end
    bus.pred_req  = 1'b0;
    bus.upd_valid = 1'b0;
    check(name, 64'(n), 64'd256);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus.pred_req = 1'b0; bus.pred_pc = '0;
    bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0;
    bus.upd_target = '0; bus.upd_pred_taken = 1'b0; bus.upd_pred_target = '0;
    #2;
    check("reset_ready",          64'(ready),               64'd0);
    check("reset_pred_valid",     64'(bus.pred_resp_valid), 64'd0);
    check("reset_pred_target",    64'(bus.pred_target),     64'd0);
    check("reset_redirect_valid", 64'(bus.redirect_valid),  64'd0);
    check("reset_redirect_pc",    64'(bus.redirect_pc),     64'd0);

    // Reset in the middle of the sweep: full re-sweep after release.
    @(posedge clk); #1; reset_n = 1'b1;
    repeat (100) begin @(posedge clk); #1; end
    check("midsweep_ready", 64'(ready), 64'd0);
    reset_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b1;
    wait_ready("init_cycles");

    // Untrained lookup
    set_pred(48'h100, 1'b0, 1'b0, 48'h104); tick();
    // Train: 01->10, mispredicted as not taken
    set_upd(48'h100, 1'b1, 48'h800, 1'b0, 48'h104, 1'b1, 48'h800); tick();
    set_pred(48'h100, 1'b1, 1'b1, 48'h800); tick();
    // Correctly predicted taken x3: 10->11->11->11, no redirect
    repeat (3) begin set_upd(48'h100, 1'b1, 48'h800, 1'b1, 48'h800, 1'b0, '0); tick(); end
    set_pred(48'h100, 1'b1, 1'b1, 48'h800); tick();
    // Two not-taken, back-to-back redirects: 11->10->01
    repeat (2) begin set_upd(48'h100, 1'b0, 48'h800, 1'b1, 48'h800, 1'b1, 48'h104); tick(); end
    set_pred(48'h100, 1'b0, 1'b1, 48'h104); tick();
    // Same-cycle predict/update: old counter 01 seen, update 01->10 commits
    set_pred(48'h100, 1'b0, 1'b1, 48'h104);
    set_upd(48'h100, 1'b1, 48'h800, 1'b0, 48'h104, 1'b1, 48'h800); tick();
    set_pred(48'h100, 1'b1, 1'b1, 48'h800); tick();
    // Alias: 0x500 shares idx 0x40 with tag 1
    set_pred(48'h500, 1'b0, 1'b0, 48'h504); tick();
    set_upd(48'h500, 1'b1, 48'h900, 1'b0, 48'h504, 1'b1, 48'h900); tick();
    set_pred(48'h100, 1'b0, 1'b0, 48'h104); tick();
    set_pred(48'h500, 1'b1, 1'b1, 48'h900); tick();
    // Direction right, target wrong
    set_upd(48'h500, 1'b1, 48'hA00, 1'b1, 48'h900, 1'b1, 48'hA00); tick();
    set_pred(48'h500, 1'b1, 1'b1, 48'hA00); tick();
    // Correct not-taken: no redirect, counter 01->00
    set_upd(48'h200, 1'b0, 48'h0, 1'b0, 48'h204, 1'b0, '0); tick();
    set_pred(48'h200, 1'b0, 1'b0, 48'h204); tick();
    // Fall-through wraps modulo 2^48
    set_pred(48'hFFFF_FFFF_FFFC, 1'b0, 1'b0, 48'h0); tick();
    set_upd(48'hFFFF_FFFF_FFFC, 1'b0, 48'h0, 1'b1, 48'h1234, 1'b1, 48'h0); tick();
    // Idle cycles exercise hold checks
    repeat (4) begin @(posedge clk); #1; end

    check("pred_pending",     64'(pq.size()), 64'd0);
    check("redirect_pending", 64'(rq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
